// File: rtl/sorted_array_writer.sv
// sorted_array_writer
//   Insertion-sorts incoming values into a single-port RAM (2-cycle read latency)
//   so the binary searcher can read an ordered array. One value is accepted per
//   in_valid/in_ready handshake. Entries that belong after the new value are moved
//   up one slot, walking downward from the top of the array, and then the value is
//   written into the gap. Equal values stop the shift, so duplicates keep their
//   arrival order.
//
//   Configuration macro: SORTED_WRITER_DESCEND_EN
//     undefined : ascending order (entries greater than the new value shift up)
//     defined   : descending order (entries less than the new value shift up)
//
//   Ports
//     clk, reset          clock, synchronous active-high reset
//     in_valid/in_data    value offered for insertion
//     in_ready            high in IDLE when the array is not full
//     clear               empties the array (count <= 0); honoured in IDLE only
//     done                one-cycle pulse when an insertion completes
//     full, count         occupancy (count is 0..DEPTH)
//     mem_addr/mem_wren/mem_wdata/mem_rdata   search RAM port, owned while busy
module sorted_array_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  clear,
  output logic                  done,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH:0]   ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] A_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, CHECK, WAIT, DECIDE, FINISH} state_t;

  state_t                      ps_q, ps_d;
  logic signed [ADDR_WIDTH:0]  i_q, i_d;
  logic [DATA_WIDTH-1:0]       value_q, value_d;
  logic [ADDR_WIDTH:0]         count_q, count_d;
  logic                        done_q, done_d;
  logic                        wren_q, wren_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;

  logic                        full_w;
  logic                        shift;
  logic [ADDR_WIDTH:0]         cnt_m1;
  logic signed [ADDR_WIDTH:0]  i_m1;
  logic [ADDR_WIDTH-1:0]       addr_p1;

  assign full_w  = (count_q == DEPTH_C);
  assign cnt_m1  = count_q - ONE;
  assign i_m1    = i_q - ONE;
  assign addr_p1 = i_q[ADDR_WIDTH-1:0] + A_ONE;

`ifdef SORTED_WRITER_DESCEND_EN
  assign shift = (mem_rdata < value_q);
`else
  assign shift = (mem_rdata > value_q);
`endif

  // RAM controls are registered, so each state decides the address/enable that
  // the *next* state presents. The write data alone stays combinational because
  // the DECIDE write carries either the just-read entry or the new value.
  always_comb begin
    ps_d    = ps_q;
    i_d     = i_q;
    value_d = value_q;
    count_d = count_q;
    done_d  = 1'b0;
    wren_d  = 1'b0;
    addr_d  = addr_q;
    case (ps_q)
      IDLE: begin
        if (clear) begin
          count_d = '0;
        end else if (in_valid && !full_w) begin
          value_d = in_data;
          i_d     = cnt_m1;
          ps_d    = CHECK;
          if (count_q == '0) begin
            addr_d = '0;
            wren_d = 1'b1;
          end else begin
            addr_d = cnt_m1[ADDR_WIDTH-1:0];
          end
        end
      end
      CHECK: begin
        if (i_q[ADDR_WIDTH]) begin
          count_d = count_q + ONE;
          done_d  = 1'b1;
          addr_d  = '0;
          ps_d    = FINISH;
        end else begin
          ps_d = WAIT;
        end
      end
      WAIT: begin
        addr_d = addr_p1;
        wren_d = 1'b1;
        ps_d   = DECIDE;
      end
      DECIDE: begin
        if (shift) begin
          i_d  = i_m1;
          ps_d = CHECK;
          if (i_m1[ADDR_WIDTH]) begin
            addr_d = '0;
            wren_d = 1'b1;
          end else begin
            addr_d = i_m1[ADDR_WIDTH-1:0];
          end
        end else begin
          count_d = count_q + ONE;
          done_d  = 1'b1;
          ps_d    = FINISH;
        end
      end
      FINISH: ps_d = IDLE;
      default: ps_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q    <= IDLE;
      i_q     <= '0;
      value_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      ps_q    <= ps_d;
      i_q     <= i_d;
      value_q <= value_d;
      count_q <= count_d;
      done_q  <= done_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
    end
  end

  assign in_ready  = (ps_q == IDLE) && !full_w;
  assign done      = done_q;
  assign full      = full_w;
  assign count     = count_q;
  assign mem_addr  = addr_q;
  assign mem_wren  = wren_q;
  assign mem_wdata = (ps_q == DECIDE && shift) ? mem_rdata : value_q;

endmodule

// File: tb/tb_sorted_array_writer.sv
module tb_sorted_array_writer;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          clear = 1'b0;
  logic          done;
  logic          full;
  logic [AW:0]   count;
  logic [AW-1:0] mem_addr;
  logic          mem_wren;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  sorted_array_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .clear(clear), .done(done), .full(full), .count(count),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM, read data two cycles after the address.
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] rd1, rd2;
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr] <= mem_wdata;
    rd1 <= ram[mem_addr];
    rd2 <= rd1;
  end
  assign mem_rdata = rd2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int t;
    int n;
    int k;
    int lat;
    int cnt;
    logic [DEPTH-1:0][DW-1:0] arr;
  } exp_t;

  exp_t sbq[$];
  int   model[$];

  // Reference: count how many stored entries must move past the new value,
  // insert into the sorted list, and derive latency from the cycle costs.
  function automatic bit moves(int stored, int v);
`ifdef SORTED_WRITER_DESCEND_EN
    return stored < v;
`else
    return stored > v;
`endif
  endfunction

  task automatic insert(input int v);
    exp_t e;
    int w;
    int b;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = DW'(v);
    chk("in_ready_on_offer", in_ready, 1);
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    e.t = cyc;
    e.n = model.size();
    e.k = 0;
    foreach (model[j]) if (moves(model[j], v)) e.k++;
    model.insert(e.n - e.k, v);
    e.lat = (e.k == e.n) ? 2 + 3 * e.n : 4 + 3 * e.k;
    e.cnt = model.size();
    e.arr = '0;
    foreach (model[j]) e.arr[j] = DW'(model[j]);
    sbq.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    b = 0;
    while (sbq.size() != 0 && b < 400) begin
      @(negedge clk);
      b++;
    end
    if (sbq.size() != 0) begin
      chk("done_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  // Monitor: checks writes and each completed insertion against the scoreboard.
  int   wr_cnt = 0;
  bit   after_done = 0;
  bit   exp_ready = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      wr_cnt     = 0;
      after_done = 0;
    end else begin
      if (after_done) begin
        chk("in_ready_after_done", in_ready, exp_ready);
        after_done = 0;
      end
      if (mem_wren) begin
        if (sbq.size() == 0) chk("write_without_insert", mem_wren, 0);
        else begin
          chk("write_addr", mem_addr, sbq[0].n - wr_cnt);
          wr_cnt++;
        end
      end
      if (done) begin
        if (sbq.size() == 0) chk("done_without_insert", done, 0);
        else begin
          e = sbq.pop_front();
          chk("latency", cyc - e.t, e.lat);
          chk("count", count, e.cnt);
          chk("full", full, e.cnt == DEPTH);
          chk("write_count", wr_cnt, e.k + 1);
          for (int j = 0; j < e.cnt; j++) chk("ram_entry", ram[j], e.arr[j]);
          exp_ready  = (e.cnt != DEPTH);
          after_done = 1;
        end
        wr_cnt = 0;
      end
    end
  end

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model.delete();
    chk("clear_count", count, 0);
    chk("clear_full", full, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_done", done, 0);
    chk("rst_wren", mem_wren, 0);
    chk("rst_addr", mem_addr, 0);

    insert(100);
    insert(50);
    insert(30);
    insert(70);
    insert(10);

    // clear takes priority over a simultaneous offer
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd5;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    model.delete();
    chk("clear_beats_valid_count", count, 0);
    chk("clear_beats_valid_idle", in_ready, 1);

    insert(50);
    insert(50);

    // reset while the first read is outstanding
    n = model.size();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'd60;
    chk("mid_offer_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("check_addr", mem_addr, n - 1);
    @(negedge clk);
    chk("wait_addr", mem_addr, n - 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_count", count, 0);
    chk("midrst_done", done, 0);
    chk("midrst_wren", mem_wren, 0);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_ready", in_ready, 1);
    reset = 1'b0;
    model.delete();
    insert(7);

    // fill to capacity with plenty of duplicates
    do_clear();
    while (model.size() < DEPTH) insert(int'($urandom_range(0, 63)));
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(j);
      chk("full_ready", in_ready, 0);
      chk("full_flag", full, 1);
      chk("full_count", count, DEPTH);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("full_hold_count", count, DEPTH);
    do_clear();

    for (int j = 0; j < 20; j++) insert(int'($urandom_range(0, 255)));
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
